// File: rtl/probe_conditioner.sv
// probe_conditioner: synchronises, optionally inverts and deglitches two
// asynchronous probe pins, then emits per-channel level or edge strobes for
// the correlator's x/y inputs. Filter and outputs advance only when i_cg=1.
module probe_conditioner #(
    parameter int SYNC_STAGES = 2,   // synchroniser depth, legal range 2..4
    parameter int FILTER_W    = 4    // stability counter / filter length width
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cg,
    input  logic                i_probeX,
    input  logic                i_probeY,
    input  logic                i_invertX,
    input  logic                i_invertY,
    input  logic [FILTER_W-1:0] i_filterLenX,
    input  logic [FILTER_W-1:0] i_filterLenY,
    input  logic [1:0]          i_modeX,
    input  logic [1:0]          i_modeY,
    output logic                o_x,
    output logic                o_y
);

    localparam int NCH = 2;

    // Output mode encoding
    localparam logic [1:0] MODE_LEVEL = 2'd0;
    localparam logic [1:0] MODE_RISE  = 2'd1;
    localparam logic [1:0] MODE_FALL  = 2'd2;
    localparam logic [1:0] MODE_ANY   = 2'd3;

    localparam logic [FILTER_W-1:0] CNT_MAX = {FILTER_W{1'b1}};
    localparam logic [FILTER_W-1:0] CNT_ONE = {{(FILTER_W-1){1'b0}}, 1'b1};

    // Channel 0 is X, channel 1 is Y; everything below is indexed by channel.
    logic [NCH-1:0]      probe_vec;
    logic [NCH-1:0]      invert_vec;
    logic [NCH-1:0]      out_vec;
    logic [FILTER_W-1:0] len_arr  [NCH];
    logic [1:0]          mode_arr [NCH];

    assign probe_vec   = {i_probeY, i_probeX};
    assign invert_vec  = {i_invertY, i_invertX};
    assign len_arr[0]  = i_filterLenX;
    assign len_arr[1]  = i_filterLenY;
    assign mode_arr[0] = i_modeX;
    assign mode_arr[1] = i_modeY;

    assign o_x = out_vec[0];
    assign o_y = out_vec[1];

    // Stability counter increment that sticks at all-ones instead of wrapping.
    // At all-ones the counter is >= any filter length, so the next differing
    // cycle always commits.
    function automatic logic [FILTER_W-1:0] sat_inc(input logic [FILTER_W-1:0] cnt);
        if (cnt == CNT_MAX) begin
            return cnt;
        end
        return cnt + CNT_ONE;
    endfunction

    // Output strobe from the stable value before (cur) and after (nxt) this
    // cycle's filter update. Edge modes can only fire on an actual transition,
    // so a mode change alone never produces a pulse.
    function automatic logic out_sel(input logic [1:0] mode,
                                     input logic       nxt,
                                     input logic       cur);
        logic res;
        unique case (mode)
            MODE_LEVEL: res = nxt;
            MODE_RISE:  res = nxt & ~cur;
            MODE_FALL:  res = ~nxt & cur;
            MODE_ANY:   res = nxt ^ cur;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_p0;   // synchroniser chain, [0] is the first flop
        logic                   raw;       // synchronised and polarity-corrected value
        logic                   stab_p1;   // accepted (stable) value S
        logic                   stab_d;
        logic [FILTER_W-1:0]    cnt_p1;    // consecutive-difference counter C
        logic [FILTER_W-1:0]    cnt_d;
        logic                   out_p2;

        // Synchroniser chain: runs every cycle, independent of the clock gate.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                sync_p0 <= '0;
            end else begin
                sync_p0 <= {sync_p0[SYNC_STAGES-2:0], probe_vec[ch]};
            end
        end

        // Inversion sits after the chain so a polarity change needs no resync.
        assign raw = sync_p0[SYNC_STAGES-1] ^ invert_vec[ch];

        // Stability filter next state: a new value is accepted once it has
        // differed from S on filterLen+1 consecutive enabled cycles.
        always_comb begin
            stab_d = stab_p1;
            cnt_d  = '0;
            if (raw != stab_p1) begin
                if (cnt_p1 >= len_arr[ch]) begin
                    stab_d = raw;
                end else begin
                    cnt_d = sat_inc(cnt_p1);
                end
            end
        end

        // Filter state and output register: advance only on enabled cycles.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                stab_p1 <= 1'b0;
                cnt_p1  <= '0;
                out_p2  <= 1'b0;
            end else if (i_cg) begin
                stab_p1 <= stab_d;
                cnt_p1  <= cnt_d;
                out_p2  <= out_sel(mode_arr[ch], stab_d, stab_p1);
            end
        end

        assign out_vec[ch] = out_p2;
    end

endmodule
